// File: rtl/match_sequencer.sv
// Match-level sequencer for the game domain: serve/play/point/over control,
// score keeping and winner declaration. All outputs are registered.
module match_sequencer #(
   parameter int unsigned SERVE_DELAY_IN_CLOCKS = 10000,
   parameter int unsigned POINT_PAUSE_IN_CLOCKS = 5000,
   parameter int unsigned WIN_SCORE             = 7,
   parameter int unsigned SCORE_WIDTH           = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_pulse,
   input  logic                   ball_exit_left,
   input  logic                   ball_exit_right,
   output logic                   ball_reset,
   output logic                   ball_enable,
   output logic                   paddles_enable,
   output logic                   serve_dir,
   output logic [SCORE_WIDTH-1:0] score_1,
   output logic [SCORE_WIDTH-1:0] score_2,
   output logic                   game_over,
   output logic                   winner,
   output logic [2:0]             state_dbg
);

   localparam int unsigned MAX_DELAY = (SERVE_DELAY_IN_CLOCKS > POINT_PAUSE_IN_CLOCKS) ?
                                       SERVE_DELAY_IN_CLOCKS : POINT_PAUSE_IN_CLOCKS;
   localparam int unsigned CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [SCORE_WIDTH-1:0] r_score_1;
   logic [SCORE_WIDTH-1:0] r_score_2;
   logic                   r_serve_dir;
   logic                   r_winner;
   logic                   r_ball_reset;
   logic                   r_ball_enable;
   logic                   r_paddles_enable;
   logic                   r_game_over;

   logic [SCORE_WIDTH-1:0] w_score_1_inc;
   logic [SCORE_WIDTH-1:0] w_score_2_inc;
   logic                   w_serve_done;
   logic                   w_point_done;

   assign w_score_1_inc = r_score_1 + 1'b1;
   assign w_score_2_inc = r_score_2 + 1'b1;
   assign w_serve_done  = (r_cnt == CNT_W'(SERVE_DELAY_IN_CLOCKS - 1));
   assign w_point_done  = (r_cnt == CNT_W'(POINT_PAUSE_IN_CLOCKS - 1));

   // Output registers are loaded on the edge that enters each state, so they
   // always equal the Moore decode of the current state/counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_score_1        <= '0;
         r_score_2        <= '0;
         r_serve_dir      <= 1'b0;
         r_winner         <= 1'b0;
         r_ball_reset     <= 1'b0;
         r_ball_enable    <= 1'b0;
         r_paddles_enable <= 1'b0;
         r_game_over      <= 1'b0;
      end else begin
         r_ball_reset <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_pulse) begin
                  r_state          <= SERVE;
                  r_cnt            <= '0;
                  r_ball_reset     <= 1'b1;
                  r_paddles_enable <= 1'b1;
               end
            end
            SERVE: begin
               if (w_serve_done) begin
                  r_state       <= PLAY;
                  r_cnt         <= '0;
                  r_ball_enable <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PLAY: begin
               if (ball_exit_left || ball_exit_right) begin
                  r_cnt            <= '0;
                  r_ball_enable    <= 1'b0;
                  r_paddles_enable <= 1'b0;
                  r_state          <= POINT;
                  if (ball_exit_left && !ball_exit_right) begin
                     r_score_2   <= w_score_2_inc;
                     r_serve_dir <= 1'b0;
                     if (w_score_2_inc == SCORE_WIDTH'(WIN_SCORE)) begin
                        r_state     <= OVER;
                        r_winner    <= 1'b1;
                        r_game_over <= 1'b1;
                     end
                  end else if (ball_exit_right && !ball_exit_left) begin
                     r_score_1   <= w_score_1_inc;
                     r_serve_dir <= 1'b1;
                     if (w_score_1_inc == SCORE_WIDTH'(WIN_SCORE)) begin
                        r_state     <= OVER;
                        r_winner    <= 1'b0;
                        r_game_over <= 1'b1;
                     end
                  end
               end
            end
            POINT: begin
               if (w_point_done) begin
                  r_state          <= SERVE;
                  r_cnt            <= '0;
                  r_ball_reset     <= 1'b1;
                  r_paddles_enable <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            OVER: begin
               if (start_pulse) begin
                  r_state          <= SERVE;
                  r_cnt            <= '0;
                  r_score_1        <= '0;
                  r_score_2        <= '0;
                  r_serve_dir      <= 1'b0;
                  r_winner         <= 1'b0;
                  r_game_over      <= 1'b0;
                  r_ball_reset     <= 1'b1;
                  r_paddles_enable <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign ball_reset     = r_ball_reset;
   assign ball_enable    = r_ball_enable;
   assign paddles_enable = r_paddles_enable;
   assign serve_dir      = r_serve_dir;
   assign score_1        = r_score_1;
   assign score_2        = r_score_2;
   assign game_over      = r_game_over;
   assign winner         = r_winner;
   assign state_dbg      = r_state;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: a per-cycle vector table for a full
// match plus hand-written sequences for reset-in-SERVE and a player-1 win.
module tb_match_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_pulse = 1'b0;
   logic       ball_exit_left = 1'b0;
   logic       ball_exit_right = 1'b0;
   logic       ball_reset;
   logic       ball_enable;
   logic       paddles_enable;
   logic       serve_dir;
   logic [3:0] score_1;
   logic [3:0] score_2;
   logic       game_over;
   logic       winner;
   logic [2:0] state_dbg;

   int n_vec = 0;
   int n_bad = 0;

   match_sequencer #(
      .SERVE_DELAY_IN_CLOCKS(4),
      .POINT_PAUSE_IN_CLOCKS(3),
      .WIN_SCORE(3),
      .SCORE_WIDTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_pulse(start_pulse),
      .ball_exit_left(ball_exit_left),
      .ball_exit_right(ball_exit_right),
      .ball_reset(ball_reset),
      .ball_enable(ball_enable),
      .paddles_enable(paddles_enable),
      .serve_dir(serve_dir),
      .score_1(score_1),
      .score_2(score_2),
      .game_over(game_over),
      .winner(winner),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       start;
      logic       exl;
      logic       exr;
      logic [2:0] st;
      logic       br;
      logic       be;
      logic       pe;
      logic       sd;
      logic       go;
      logic       win;
      logic [3:0] s1;
      logic [3:0] s2;
   } vec_t;

   vec_t vecs[$];

   // Packed view of the outputs in the same order as the expected fields.
   function automatic logic [16:0] outs();
      return {state_dbg, ball_reset, ball_enable, paddles_enable, serve_dir,
              game_over, winner, score_1, score_2};
   endfunction

   task automatic add(input logic start, input logic exl, input logic exr,
                      input logic [2:0] st, input logic br, input logic be,
                      input logic pe, input logic sd, input logic go,
                      input logic win, input logic [3:0] s1, input logic [3:0] s2);
      vec_t v;
      v = '{start, exl, exr, st, br, be, pe, sd, go, win, s1, s2};
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step(input logic s, input logic l, input logic r);
      @(negedge clk);
      start_pulse     = s;
      ball_exit_left  = l;
      ball_exit_right = r;
      @(posedge clk);
      #1;
      start_pulse     = 1'b0;
      ball_exit_left  = 1'b0;
      ball_exit_right = 1'b0;
   endtask

   task automatic run_to(input logic [2:0] tgt, input string nm);
      int n;
      n = 0;
      while (state_dbg !== tgt && n < 30) begin
         step(1'b0, 1'b0, 1'b0);
         n++;
      end
      chk(nm, {29'd0, state_dbg}, {29'd0, tgt});
   endtask

   initial begin
      // start, exl, exr | st br be pe sd go win s1 s2
      add(0,0,0, 0,0,0,0,0,0,0,0,0);
      add(1,0,0, 1,1,0,1,0,0,0,0,0);
      repeat (3) add(0,0,0, 1,0,0,1,0,0,0,0,0);
      add(0,0,0, 2,0,1,1,0,0,0,0,0);
      add(0,0,1, 3,0,0,0,1,0,0,1,0);
      repeat (2) add(0,0,0, 3,0,0,0,1,0,0,1,0);
      add(0,0,0, 1,1,0,1,1,0,0,1,0);
      repeat (3) add(0,0,0, 1,0,0,1,1,0,0,1,0);
      add(0,0,0, 2,0,1,1,1,0,0,1,0);
      add(1,0,0, 2,0,1,1,1,0,0,1,0);
      add(0,1,1, 3,0,0,0,1,0,0,1,0);
      add(0,1,0, 3,0,0,0,1,0,0,1,0);
      add(0,0,0, 3,0,0,0,1,0,0,1,0);
      add(0,0,0, 1,1,0,1,1,0,0,1,0);
      add(0,0,1, 1,0,0,1,1,0,0,1,0);
      repeat (2) add(0,0,0, 1,0,0,1,1,0,0,1,0);
      add(0,0,0, 2,0,1,1,1,0,0,1,0);
      add(0,1,0, 3,0,0,0,0,0,0,1,1);
      repeat (2) add(0,0,0, 3,0,0,0,0,0,0,1,1);
      add(0,0,0, 1,1,0,1,0,0,0,1,1);
      repeat (3) add(0,0,0, 1,0,0,1,0,0,0,1,1);
      add(0,0,0, 2,0,1,1,0,0,0,1,1);
      add(0,1,0, 3,0,0,0,0,0,0,1,2);
      add(1,0,0, 3,0,0,0,0,0,0,1,2);
      add(0,0,0, 3,0,0,0,0,0,0,1,2);
      add(0,0,0, 1,1,0,1,0,0,0,1,2);
      repeat (3) add(0,0,0, 1,0,0,1,0,0,0,1,2);
      add(0,0,0, 2,0,1,1,0,0,0,1,2);
      add(0,1,0, 4,0,0,0,0,1,1,1,3);
      add(0,0,1, 4,0,0,0,0,1,1,1,3);
      add(0,1,0, 4,0,0,0,0,1,1,1,3);
      add(0,0,0, 4,0,0,0,0,1,1,1,3);
      add(1,0,0, 1,1,0,1,0,0,0,0,0);
      repeat (3) add(0,0,0, 1,0,0,1,0,0,0,0,0);
      add(0,0,0, 2,0,1,1,0,0,0,0,0);

      #3;
      chk("reset_state", {15'd0, outs()}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) step(1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         step(vecs[i].start, vecs[i].exl, vecs[i].exr);
         chk($sformatf("vec%0d", i), {15'd0, outs()},
             {15'd0, vecs[i].st, vecs[i].br, vecs[i].be, vecs[i].pe, vecs[i].sd,
              vecs[i].go, vecs[i].win, vecs[i].s1, vecs[i].s2});
      end

      // Build a 2:1 score, then reset asynchronously two cycles into SERVE.
      step(1'b0, 1'b0, 1'b1);
      run_to(3'd2, "to_play_a");
      step(1'b0, 1'b0, 1'b1);
      run_to(3'd2, "to_play_b");
      step(1'b0, 1'b1, 1'b0);
      chk("score_2_1", {24'd0, score_1, score_2}, {24'd0, 4'd2, 4'd1});
      run_to(3'd1, "to_serve");
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("serve_cnt2", {29'd0, state_dbg}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset", {15'd0, outs()}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("idle_after_reset", {15'd0, outs()}, 32'd0);

      // Player 1 takes three straight points.
      step(1'b1, 1'b0, 1'b0);
      chk("restart_serve", {15'd0, outs()},
          {15'd0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0});
      run_to(3'd2, "p1_play_1");
      step(1'b0, 1'b0, 1'b1);
      run_to(3'd2, "p1_play_2");
      step(1'b0, 1'b0, 1'b1);
      run_to(3'd2, "p1_play_3");
      step(1'b0, 1'b0, 1'b1);
      chk("p1_wins", {15'd0, outs()},
          {15'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
